// File: rtl/exec_pkg.sv
// Shared constants, lane state type and single-cycle datapath helpers for the execute/writeback stage.
package exec_pkg;

    localparam int unsigned XLEN   = 16;
    localparam int unsigned OP_W   = 7;
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned FT_W   = 2;
    localparam int unsigned PROD_W = 2 * XLEN;

    // Function types
    localparam logic [FT_W-1:0] FT_ALU   = 2'b00;
    localparam logic [FT_W-1:0] FT_SHIFT = 2'b01;
    localparam logic [FT_W-1:0] FT_MUL   = 2'b10;
    localparam logic [FT_W-1:0] FT_RSVD  = 2'b11;

    // ALU opcodes
    localparam logic [OP_W-1:0] OP_ADD = 7'h00;
    localparam logic [OP_W-1:0] OP_SUB = 7'h01;
    localparam logic [OP_W-1:0] OP_AND = 7'h02;
    localparam logic [OP_W-1:0] OP_OR  = 7'h03;
    localparam logic [OP_W-1:0] OP_XOR = 7'h04;
    localparam logic [OP_W-1:0] OP_NOT = 7'h05;
    localparam logic [OP_W-1:0] OP_MOV = 7'h06;

    // Shift opcodes
    localparam logic [OP_W-1:0] OP_SHL = 7'h00;
    localparam logic [OP_W-1:0] OP_SHR = 7'h01;
    localparam logic [OP_W-1:0] OP_ASR = 7'h02;

    // Multiply opcodes
    localparam logic [OP_W-1:0] OP_MUL  = 7'h00;
    localparam logic [OP_W-1:0] OP_MULH = 7'h01;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } lane_state_e;

    // True when the type/opcode pair names a defined operation.
    function automatic logic op_legal(input logic [FT_W-1:0] ft, input logic [OP_W-1:0] op);
        logic ok;
        ok = 1'b0;
        case (ft)
            FT_ALU:   ok = (op <= OP_MOV);
            FT_SHIFT: ok = (op <= OP_ASR);
            FT_MUL:   ok = (op <= OP_MULH);
            default:  ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Single-cycle ALU result, wrapping modulo 2^XLEN.
    function automatic logic [XLEN-1:0] alu_calc(input logic [OP_W-1:0] op,
                                                 input logic [XLEN-1:0] a,
                                                 input logic [XLEN-1:0] b);
        logic [XLEN-1:0] r;
        r = '0;
        case (op)
            OP_ADD:  r = a + b;
            OP_SUB:  r = a - b;
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            OP_NOT:  r = ~a;
            OP_MOV:  r = b;
            default: r = '0;
        endcase
        return r;
    endfunction

    // Single-cycle shifter; amount is the low nibble of the second operand.
    function automatic logic [XLEN-1:0] shift_calc(input logic [OP_W-1:0] op,
                                                   input logic [XLEN-1:0] a,
                                                   input logic [3:0]      amt);
        logic [XLEN-1:0] r;
        r = '0;
        case (op)
            OP_SHL:  r = a << amt;
            OP_SHR:  r = a >> amt;
            OP_ASR:  r = XLEN'($signed(a) >>> amt);
            default: r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/exec_lane.sv
// One execute lane: IDLE/MUL FSM, ALU/shift datapath, shift-add multiplier and sticky flags.
module exec_lane
    import exec_pkg::*;
#(
    parameter int unsigned MUL_CYCLES = 4
) (
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic              enable,
    input  logic              wb_req,
    input  logic [OP_W-1:0]   opcode,
    input  logic [ADDR_W-1:0] addr,
    input  logic [XLEN-1:0]   prim,
    input  logic [XLEN-1:0]   sec,
    input  logic [FT_W-1:0]   ftype,
    input  logic              suppress,
    output logic              busy,
    output logic              wb,
    output logic [ADDR_W-1:0] wb_addr,
    output logic [XLEN-1:0]   wb_val,
    output logic              zero,
    output logic              overrun,
    output logic              illegal,
    output logic              wb_nxt_c,
    output logic [ADDR_W-1:0] wb_addr_nxt_c
);

    localparam int unsigned BPC   = XLEN / MUL_CYCLES;
    localparam int unsigned CNT_W = 5;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MUL_CYCLES - 1);

    lane_state_e        state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [PROD_W-1:0]  mcand_q, mcand_d;
    logic [XLEN-1:0]    mplier_q, mplier_d;
    logic [PROD_W-1:0]  acc_q, acc_d;
    logic [PROD_W-1:0]  acc_step;
    logic               mhigh_q, mhigh_d;
    logic               mwb_q, mwb_d;
    logic [ADDR_W-1:0]  maddr_q, maddr_d;

    logic               wb_d;
    logic [ADDR_W-1:0]  addr_d;
    logic [XLEN-1:0]    val_d;
    logic               overrun_d;
    logic               illegal_d;

    // Partial products for the multiplier bits retired this cycle.
    always_comb begin
        acc_step = acc_q;
        for (int i = 0; i < int'(BPC); i++) begin
            if (mplier_q[i]) begin
                acc_step = acc_step + (mcand_q << i);
            end
        end
    end

    // Next-state and next-output logic for the lane.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;
        mhigh_d   = mhigh_q;
        mwb_d     = mwb_q;
        maddr_d   = maddr_q;
        wb_d      = 1'b0;
        addr_d    = wb_addr;
        val_d     = wb_val;
        overrun_d = overrun;
        illegal_d = illegal;

        unique case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    if (!op_legal(ftype, opcode)) begin
                        illegal_d = 1'b1;
                    end else if (ftype == FT_MUL) begin
                        state_d  = ST_MUL;
                        cnt_d    = '0;
                        mcand_d  = PROD_W'(prim);
                        mplier_d = sec;
                        acc_d    = '0;
                        mhigh_d  = (opcode == OP_MULH);
                        mwb_d    = wb_req;
                        maddr_d  = addr;
                    end else begin
                        wb_d   = wb_req;
                        addr_d = addr;
                        val_d  = (ftype == FT_ALU) ? alu_calc(opcode, prim, sec)
                                                   : shift_calc(opcode, prim, sec[3:0]);
                    end
                end
            end
            ST_MUL: begin
                // Ops arriving mid-multiply are dropped and flagged.
                if (enable) begin
                    overrun_d = 1'b1;
                end
                acc_d    = acc_step;
                mcand_d  = mcand_q << BPC;
                mplier_d = mplier_q >> BPC;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_CNT) begin
                    state_d = ST_IDLE;
                    wb_d    = mwb_q;
                    addr_d  = maddr_q;
                    val_d   = mhigh_q ? acc_step[PROD_W-1:XLEN] : acc_step[XLEN-1:0];
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        wb_nxt_c      = wb_d;
        wb_addr_nxt_c = addr_d;
    end

    // Lane state register.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Multiplier working registers.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            mhigh_q  <= 1'b0;
            mwb_q    <= 1'b0;
            maddr_q  <= '0;
        end else begin
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            mhigh_q  <= mhigh_d;
            mwb_q    <= mwb_d;
            maddr_q  <= maddr_d;
        end
    end

    // Registered writeback port and flags; suppression from the other lane gates the enable and zero.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            busy    <= 1'b0;
            wb      <= 1'b0;
            wb_addr <= '0;
            wb_val  <= '0;
            zero    <= 1'b0;
            overrun <= 1'b0;
            illegal <= 1'b0;
        end else begin
            busy    <= (state_d == ST_MUL);
            wb      <= wb_d & ~suppress;
            wb_addr <= addr_d;
            wb_val  <= val_d;
            zero    <= wb_d & ~suppress & (val_d == '0);
            overrun <= overrun_d;
            illegal <= illegal_d;
        end
    end

endmodule

// File: rtl/exec_wb_unit.sv
// Dual-lane execute/writeback stage; lane B wins same-address writeback collisions.
module exec_wb_unit
    import exec_pkg::*;
#(
    parameter int unsigned MUL_CYCLES = 4,
    parameter int unsigned DATA_W     = XLEN
) (
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic              enableA_i,
    input  logic              enableB_i,
    input  logic              wbA_i,
    input  logic              wbB_i,
    input  logic [6:0]        opCodeA_i,
    input  logic [6:0]        opCodeB_i,
    input  logic [4:0]        regAddrA_i,
    input  logic [4:0]        regAddrB_i,
    input  logic [DATA_W-1:0] primOperandA_i,
    input  logic [DATA_W-1:0] primOperandB_i,
    input  logic [DATA_W-1:0] secOperandA_i,
    input  logic [DATA_W-1:0] secOperandB_i,
    input  logic [1:0]        functionTypeA_i,
    input  logic [1:0]        functionTypeB_i,
    output logic              busyA_o,
    output logic              busyB_o,
    output logic              wbA_o,
    output logic              wbB_o,
    output logic [4:0]        wbAddrA_o,
    output logic [4:0]        wbAddrB_o,
    output logic [DATA_W-1:0] wbValA_o,
    output logic [DATA_W-1:0] wbValB_o,
    output logic              zeroA_o,
    output logic              zeroB_o,
    output logic              overrunA_o,
    output logic              overrunB_o,
    output logic              illegalA_o,
    output logic              illegalB_o
);

    logic              wb_nxt_a_c, wb_nxt_b_c;
    logic [ADDR_W-1:0] addr_nxt_a_c, addr_nxt_b_c;
    logic              suppress_a_c;

    // Lane A loses its write when both lanes target the same register next cycle.
    assign suppress_a_c = wb_nxt_a_c & wb_nxt_b_c & (addr_nxt_a_c == addr_nxt_b_c);

    exec_lane #(.MUL_CYCLES(MUL_CYCLES)) u_lane_a (
        .clock_i       (clock_i),
        .reset_i       (reset_i),
        .enable        (enableA_i),
        .wb_req        (wbA_i),
        .opcode        (opCodeA_i),
        .addr          (regAddrA_i),
        .prim          (primOperandA_i),
        .sec           (secOperandA_i),
        .ftype         (functionTypeA_i),
        .suppress      (suppress_a_c),
        .busy          (busyA_o),
        .wb            (wbA_o),
        .wb_addr       (wbAddrA_o),
        .wb_val        (wbValA_o),
        .zero          (zeroA_o),
        .overrun       (overrunA_o),
        .illegal       (illegalA_o),
        .wb_nxt_c      (wb_nxt_a_c),
        .wb_addr_nxt_c (addr_nxt_a_c)
    );

    exec_lane #(.MUL_CYCLES(MUL_CYCLES)) u_lane_b (
        .clock_i       (clock_i),
        .reset_i       (reset_i),
        .enable        (enableB_i),
        .wb_req        (wbB_i),
        .opcode        (opCodeB_i),
        .addr          (regAddrB_i),
        .prim          (primOperandB_i),
        .sec           (secOperandB_i),
        .ftype         (functionTypeB_i),
        .suppress      (1'b0),
        .busy          (busyB_o),
        .wb            (wbB_o),
        .wb_addr       (wbAddrB_o),
        .wb_val        (wbValB_o),
        .zero          (zeroB_o),
        .overrun       (overrunB_o),
        .illegal       (illegalB_o),
        .wb_nxt_c      (wb_nxt_b_c),
        .wb_addr_nxt_c (addr_nxt_b_c)
    );

endmodule

// File: doc/exec_wb_unit.md
Name: exec_wb_unit

Overview:
- Dual-lane execute/writeback stage sitting between the register-read stage and the register file write ports.
- Per lane, accepts one resolved operation: enable, writeback flag, opcode, destination address, two 16-bit operands and a function type.
- Computes ALU, shift or iterative-multiply results and drives the register file writeback ports (enable, address, value) for lanes A and B.

Parameters:
- MUL_CYCLES, 4, multiply latency in cycles; legal values 1, 2, 4, 8, 16; multiplier bits retired per cycle = 16/MUL_CYCLES.
- DATA_W, 16, operand/result width; fixed at 16 and not overridden.

Ports:
- clock_i  in  1  single clock, rising edge
- reset_i  in  1  asynchronous, active-high reset
- enableA_i, enableB_i  in  1  operation valid for lane
- wbA_i, wbB_i  in  1  result must be written back
- opCodeA_i, opCodeB_i  in  7  operation code
- regAddrA_i, regAddrB_i  in  5  destination register
- primOperandA_i, primOperandB_i  in  16  operand 1
- secOperandA_i, secOperandB_i  in  16  operand 2
- functionTypeA_i, functionTypeB_i  in  2  00 ALU, 01 shift, 10 multiply, 11 reserved
- busyA_o, busyB_o  out  1  lane multiply in progress; upstream must not issue
- wbA_o, wbB_o  out  1  register file write enable
- wbAddrA_o, wbAddrB_o  out  5  write address
- wbValA_o, wbValB_o  out  16  write data
- zeroA_o, zeroB_o  out  1  result==0, qualified by wbX_o
- overrunA_o, overrunB_o  out  1  sticky: enable received while busy
- illegalA_o, illegalB_o  out  1  sticky: reserved type or undefined opcode

Behaviour:
- Reset (asynchronous, immediate): all outputs 0; lane FSMs go to IDLE; the multiply counter and accumulator clear. A multiply in flight is discarded with no writeback.
- Lane FSM states: IDLE and MUL. Lanes are fully independent apart from the collision rule.
- ALU operations (type 00), single cycle. Opcodes: 0x00 ADD, 0x01 SUB (prim-sec), 0x02 AND, 0x03 OR, 0x04 XOR, 0x05 NOT prim, 0x06 MOV sec. Results wrap modulo 2^16.
- Shift operations (type 01), single cycle. Opcodes: 0x00 SHL, 0x01 SHR logical, 0x02 ASR. Shift amount is sec[3:0].
- Single-cycle latency: with enable sampled at edge k, wbX_o, addr, val and zero are valid in the cycle following edge k, for one cycle only.
- wbX_o follows the wb flag. When the flag is 0, the op executes, but wbX_o stays 0 and val/addr are don't-care.
- Multiply (type 10): 0x00 MUL returns low 16 bits of the unsigned 32-bit product; 0x01 MULH returns the high 16 bits.
  - Accept at edge k moves the lane to MUL and latches operands, opcode, addr and wb flag.
  - busyX_o is high after edges k through k+MUL_CYCLES-1.
  - Result is presented after edge k+MUL_CYCLES; the lane returns to IDLE on that same edge.
  - Implementation is shift-add, 16/MUL_CYCLES multiplier bits per cycle.
- Enable while busy: the op is dropped, overrunX_o is set, and the multiply continues unaffected.
- Enable in the cycle busy falls (result cycle): the op is accepted normally.
- Reserved type or undefined opcode: illegalX_o is set and wbX_o stays 0. Sticky flags clear only on reset.
- Collision: if wbA_o and wbB_o would both assert in the same cycle with equal addresses, lane B wins and wbA_o is forced 0. Differing addresses both write.
- zeroX_o is registered alongside the result.

Decomposition:
- Package exec_pkg:
  - function-type constants FT_ALU, FT_SHIFT, FT_MUL, FT_RSVD
  - opcode constants per type
  - lane FSM state typedef
- Sub-module exec_lane, instantiated twice: one lane's FSM, datapath, multiplier and flags.
- The top level adds only the collision suppression.

Test Plan:
- Lane A ADD 0xFFFF+0x0002, addr 3, wb=1 -> next cycle wbA_o=1, addr 3, val 0x0001, zeroA_o=0.
- Lane B ASR 0x8000 by sec=4 -> val 0xF800; SUB 5-5 -> val 0, zeroB_o=1.
- MUL_CYCLES=4, lane A MULH 0x1234*0x5678 -> busy for 4 cycles, then val 0x0626. Lane B ADD issued meanwhile writes back after 1 cycle.
- Lane A enable during busy -> overrunA_o=1, the dropped op is never written, and the original MUL result is still correct.
- Both lanes issue single-cycle ops to addr 7 in the same cycle -> wbB_o=1, wbA_o=0. To addrs 7 and 8 -> both write.
- Reset asserted mid-multiply -> outputs 0 immediately, no writeback after release; type 11 op afterwards -> illegal flag=1, wb=0.
